// File: rtl/xbus_pkg.sv
// Shared XBUS arbiter definitions: FSM state encoding, default widths, round-robin helper.
package xbus_pkg;

   typedef enum logic {
      StIdle = 1'b0,
      StBusy = 1'b1
   } xbus_state_e;

   localparam int unsigned XbusAddrWidth   = 32;
   localparam int unsigned XbusDataWidth   = 32;
   localparam int unsigned XbusSelectWidth = 4;
   localparam int unsigned XbusNumMasters  = 2;
   localparam int unsigned XbusTimeout     = 1024;

   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/xbus_master_arbiter_if.sv
// XBUS arbiter bundle: flattened per-master requests, shared bridge side, grant/busy status.
interface xbus_master_arbiter_if
   import xbus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH   = XbusAddrWidth,
   parameter int unsigned DATA_WIDTH   = XbusDataWidth,
   parameter int unsigned SELECT_WIDTH = XbusSelectWidth,
   parameter int unsigned NUM_MASTERS  = XbusNumMasters
) ();

   logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i;
   logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i;
   logic [NUM_MASTERS*SELECT_WIDTH-1:0] m_sel_i;
   logic [NUM_MASTERS-1:0]              m_we_i;
   logic [NUM_MASTERS-1:0]              m_stb_i;
   logic [NUM_MASTERS-1:0]              m_cyc_i;
   logic [DATA_WIDTH-1:0]               m_dat_o;
   logic [NUM_MASTERS-1:0]              m_ack_o;
   logic [NUM_MASTERS-1:0]              m_err_o;

   logic [ADDR_WIDTH-1:0]               s_adr_o;
   logic [DATA_WIDTH-1:0]               s_dat_o;
   logic [SELECT_WIDTH-1:0]             s_sel_o;
   logic                                s_we_o;
   logic                                s_stb_o;
   logic                                s_cyc_o;
   logic [DATA_WIDTH-1:0]               s_dat_i;
   logic                                s_ack_i;

   logic [NUM_MASTERS-1:0]              grant_o;
   logic                                busy_o;

   // Arbiter side: serves the requesting masters and drives the bridge.
   modport slave (
      input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
      output m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
      output grant_o, busy_o
   );

   // Environment side: masters and bridge.
   modport master (
      output m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i, s_dat_i, s_ack_i,
      input  m_dat_o, m_ack_o, m_err_o, s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
      input  grant_o, busy_o
   );

endinterface

// File: rtl/xbus_master_arbiter_rr_arbiter.sv
// Round-robin selector: first active request at or after the pointer, wrapping modulo NUM_MASTERS.
module rr_arbiter #(
   parameter int unsigned NUM_MASTERS = 2
) (
   input  logic [NUM_MASTERS-1:0]         req,
   input  logic [$clog2(NUM_MASTERS)-1:0] pointer,
   output logic [NUM_MASTERS-1:0]         grant,
   output logic [$clog2(NUM_MASTERS)-1:0] index,
   output logic                           valid
);

   localparam int unsigned IdxW = $clog2(NUM_MASTERS);

   logic [IdxW-1:0]        cand [NUM_MASTERS];
   logic [NUM_MASTERS-1:0] hit;
   logic [NUM_MASTERS-1:0] first;
   logic [NUM_MASTERS:0]   seen;
   logic [NUM_MASTERS-1:0] grant_acc [NUM_MASTERS+1];
   logic [IdxW-1:0]        index_acc [NUM_MASTERS+1];

   assign seen[0]      = 1'b0;
   assign grant_acc[0] = '0;
   assign index_acc[0] = '0;

   // Position i of the search visits master (pointer + i) mod NUM_MASTERS.
   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_pos
      assign cand[i]          = IdxW'((32'(pointer) + i) % NUM_MASTERS);
      assign hit[i]           = req[cand[i]];
      assign first[i]         = hit[i] & ~seen[i];
      assign seen[i+1]        = seen[i] | hit[i];
      assign grant_acc[i+1]   = grant_acc[i] |
                                (first[i] ? (NUM_MASTERS'(1) << cand[i]) : '0);
      assign index_acc[i+1]   = index_acc[i] | (first[i] ? cand[i] : '0);
   end

   assign grant = grant_acc[NUM_MASTERS];
   assign index = index_acc[NUM_MASTERS];
   assign valid = seen[NUM_MASTERS];

endmodule

// File: rtl/xbus_master_arbiter.sv
// Round-robin XBUS master arbiter in front of the XBUS-to-APB bridge.
// Optional BUSY watchdog enabled with the XBUS_ARB_TIMEOUT_EN macro.
module xbus_master_arbiter
   import xbus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = XbusAddrWidth,
   parameter int unsigned DATA_WIDTH     = XbusDataWidth,
   parameter int unsigned SELECT_WIDTH   = XbusSelectWidth,
   parameter int unsigned NUM_MASTERS    = XbusNumMasters,
   parameter int unsigned TIMEOUT_CYCLES = XbusTimeout
) (
   input logic                  clk,
   input logic                  reset,
   xbus_master_arbiter_if.slave bus
);

   localparam int unsigned IdxW = $clog2(NUM_MASTERS);

   if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("xbus_master_arbiter: unsupported NUM_MASTERS or TIMEOUT_CYCLES");
   end

   xbus_state_e            state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IdxW-1:0]        gidx_q, gidx_d;
   logic [IdxW-1:0]        ptr_q, ptr_d;

   logic [NUM_MASTERS-1:0] req;
   logic [NUM_MASTERS-1:0] arb_grant;
   logic [IdxW-1:0]        arb_idx;
   logic                   arb_valid;
   logic                   active;
   logic                   timeout;

   logic [ADDR_WIDTH-1:0]   adr_arr [NUM_MASTERS];
   logic [DATA_WIDTH-1:0]   dat_arr [NUM_MASTERS];
   logic [SELECT_WIDTH-1:0] sel_arr [NUM_MASTERS];

   logic [ADDR_WIDTH-1:0]   mir_adr, last_adr_q;
   logic [DATA_WIDTH-1:0]   mir_dat, last_dat_q;
   logic [SELECT_WIDTH-1:0] mir_sel, last_sel_q;
   logic                    mir_we, last_we_q;

   assign req = bus.m_stb_i & bus.m_cyc_i;

   for (genvar k = 0; k < NUM_MASTERS; k++) begin : g_unpack
      assign adr_arr[k] = bus.m_adr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
      assign dat_arr[k] = bus.m_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
      assign sel_arr[k] = bus.m_sel_i[k*SELECT_WIDTH +: SELECT_WIDTH];
   end

   rr_arbiter #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_rr_arbiter (
      .req    (req),
      .pointer(ptr_q),
      .grant  (arb_grant),
      .index  (arb_idx),
      .valid  (arb_valid)
   );

   // Outputs fall to reset values as soon as reset is seen, so a mid-BUSY reset never acks.
   assign active = (state_q == StBusy) && !reset;

   assign mir_adr = adr_arr[gidx_q];
   assign mir_dat = dat_arr[gidx_q];
   assign mir_sel = sel_arr[gidx_q];
   assign mir_we  = bus.m_we_i[gidx_q];

`ifdef XBUS_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);

   logic [CntW-1:0] cnt_q, cnt_d;

   assign cnt_d   = (state_q == StIdle) ? '0 : cnt_q + 1'b1;
   assign timeout = active && !bus.s_ack_i && bus.m_cyc_i[gidx_q] &&
                    (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign bus.m_err_o = timeout ? grant_q : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout     = 1'b0;
   assign bus.m_err_o = '0;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         StIdle: begin
            if (arb_valid) begin
               state_d = StBusy;
               grant_d = arb_grant;
               gidx_d  = arb_idx;
               ptr_d   = IdxW'(rr_next(32'(arb_idx), NUM_MASTERS));
            end
         end
         StBusy: begin
            // Ack wins over a simultaneous cyc drop; the pointer already moved at grant time.
            if (bus.s_ack_i || !bus.m_cyc_i[gidx_q] || timeout) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         grant_q <= '0;
         gidx_q  <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         ptr_q   <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_adr_q <= '0;
         last_dat_q <= '0;
         last_sel_q <= '0;
         last_we_q  <= 1'b0;
      end else if (active) begin
         last_adr_q <= mir_adr;
         last_dat_q <= mir_dat;
         last_sel_q <= mir_sel;
         last_we_q  <= mir_we;
      end
   end

   always_comb begin
      bus.s_stb_o = active;
      bus.s_cyc_o = active;
      bus.busy_o  = active;
      bus.grant_o = active ? grant_q : '0;
      bus.m_ack_o = active ? (grant_q & {NUM_MASTERS{bus.s_ack_i}}) : '0;
      bus.m_dat_o = bus.s_dat_i;
      if (active) begin
         bus.s_adr_o = mir_adr;
         bus.s_dat_o = mir_dat;
         bus.s_sel_o = mir_sel;
         bus.s_we_o  = mir_we;
      end else if (reset) begin
         bus.s_adr_o = '0;
         bus.s_dat_o = '0;
         bus.s_sel_o = '0;
         bus.s_we_o  = 1'b0;
      end else begin
         bus.s_adr_o = last_adr_q;
         bus.s_dat_o = last_dat_q;
         bus.s_sel_o = last_sel_q;
         bus.s_we_o  = last_we_q;
      end
   end

endmodule

// File: tb/tb_xbus_master_arbiter.sv
// Directed bench for xbus_master_arbiter (two masters, TIMEOUT_CYCLES=16).
module tb_xbus_master_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 4;
   localparam int unsigned NM = 2;
   localparam int unsigned TO = 16;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   int unsigned total = 0;
   int unsigned fails = 0;

   xbus_master_arbiter_if #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .SELECT_WIDTH(SW),
      .NUM_MASTERS (NM)
   ) bus ();

   xbus_master_arbiter #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .SELECT_WIDTH  (SW),
      .NUM_MASTERS   (NM),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic we, input logic rq);
      bus.m_adr_i[k*AW +: AW] = adr;
      bus.m_dat_i[k*DW +: DW] = dat;
      bus.m_sel_i[k*SW +: SW] = sel;
      bus.m_we_i[k]           = we;
      bus.m_stb_i[k]          = rq;
      bus.m_cyc_i[k]          = rq;
   endtask

   initial begin
      bus.m_adr_i = '0;
      bus.m_dat_i = '0;
      bus.m_sel_i = '0;
      bus.m_we_i  = '0;
      bus.m_stb_i = '0;
      bus.m_cyc_i = '0;
      bus.s_dat_i = '0;
      bus.s_ack_i = 1'b0;
      tick();
      tick();
      chk("rst_grant", bus.grant_o, 2'b00);
      chk("rst_busy", bus.busy_o, 1'b0);
      chk("rst_ack", bus.m_ack_o, 2'b00);
      chk("rst_err", bus.m_err_o, 2'b00);
      chk("rst_stb", bus.s_stb_o, 1'b0);
      chk("rst_cyc", bus.s_cyc_o, 1'b0);
      chk("rst_we", bus.s_we_o, 1'b0);
      chk("rst_adr", bus.s_adr_o, 32'h0);
      reset = 1'b0;
      tick();

      // m0 read, acked together with its cyc drop
      drive(0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b1);
      tick();
      chk("rd_grant", bus.grant_o, 2'b01);
      chk("rd_stb", bus.s_stb_o, 1'b1);
      chk("rd_cyc", bus.s_cyc_o, 1'b1);
      chk("rd_busy", bus.busy_o, 1'b1);
      chk("rd_adr", bus.s_adr_o, 32'h10);
      chk("rd_we", bus.s_we_o, 1'b0);
      bus.s_ack_i = 1'b1;
      bus.s_dat_i = 32'hDEADBEEF;
      drive(0, 32'h10, 32'h0, 4'hF, 1'b0, 1'b0);
      #1;
      chk("rd_ack", bus.m_ack_o, 2'b01);
      chk("rd_dat", bus.m_dat_o, 32'hDEADBEEF);
      tick();
      chk("rd_idle_ack", bus.m_ack_o, 2'b00);
      bus.s_ack_i = 1'b0;
      chk("rd_idle_busy", bus.busy_o, 1'b0);
      chk("rd_idle_stb", bus.s_stb_o, 1'b0);
      chk("rd_idle_adr", bus.s_adr_o, 32'h10);

      // m1 write mirrored while BUSY
      drive(1, 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b1);
      tick();
      chk("wr_grant", bus.grant_o, 2'b10);
      chk("wr_adr", bus.s_adr_o, 32'h20);
      chk("wr_dat", bus.s_dat_o, 32'h12345678);
      chk("wr_sel", bus.s_sel_o, 4'hF);
      chk("wr_we", bus.s_we_o, 1'b1);
      tick();
      chk("wr_wait_busy", bus.busy_o, 1'b1);
      chk("wr_wait_ack", bus.m_ack_o, 2'b00);
      chk("wr_wait_adr", bus.s_adr_o, 32'h20);
      bus.s_ack_i = 1'b1;
      #1;
      chk("wr_ack", bus.m_ack_o, 2'b10);
      drive(1, 32'h20, 32'h12345678, 4'hF, 1'b1, 1'b0);
      tick();
      bus.s_ack_i = 1'b0;
      chk("wr_idle_stb", bus.s_stb_o, 1'b0);
      chk("wr_idle_we", bus.s_we_o, 1'b1);
      chk("wr_idle_dat", bus.s_dat_o, 32'h12345678);

      // both request and hold: m0, m1, m0 with a gap between grants
      drive(0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b1);
      drive(1, 32'h200, 32'h0, 4'hF, 1'b0, 1'b1);
      tick();
      chk("rr1_grant", bus.grant_o, 2'b01);
      chk("rr1_adr", bus.s_adr_o, 32'h100);
      bus.s_ack_i = 1'b1;
      #1;
      chk("rr1_ack", bus.m_ack_o, 2'b01);
      tick();
      bus.s_ack_i = 1'b0;
      chk("rr1_gap_grant", bus.grant_o, 2'b00);
      chk("rr1_gap_busy", bus.busy_o, 1'b0);
      tick();
      chk("rr2_grant", bus.grant_o, 2'b10);
      chk("rr2_adr", bus.s_adr_o, 32'h200);
      bus.s_ack_i = 1'b1;
      tick();
      bus.s_ack_i = 1'b0;
      chk("rr2_gap_busy", bus.busy_o, 1'b0);
      tick();
      chk("rr3_grant", bus.grant_o, 2'b01);
      bus.s_ack_i = 1'b1;
      drive(0, 32'h100, 32'h0, 4'hF, 1'b0, 1'b0);
      drive(1, 32'h200, 32'h0, 4'hF, 1'b0, 1'b0);
      tick();
      bus.s_ack_i = 1'b0;

      // m0 abandons its cycle; m1 waiting gets the next grant
      drive(0, 32'h300, 32'h0, 4'hF, 1'b0, 1'b1);
      tick();
      chk("drop_grant", bus.grant_o, 2'b01);
      drive(0, 32'h300, 32'h0, 4'hF, 1'b0, 1'b0);
      drive(1, 32'h400, 32'h0, 4'hF, 1'b0, 1'b1);
      #1;
      chk("drop_no_ack", bus.m_ack_o, 2'b00);
      tick();
      chk("drop_idle_busy", bus.busy_o, 1'b0);
      chk("drop_idle_ack", bus.m_ack_o, 2'b00);
      tick();
      chk("drop_next_grant", bus.grant_o, 2'b10);
      chk("drop_next_adr", bus.s_adr_o, 32'h400);
      bus.s_ack_i = 1'b1;
      drive(1, 32'h400, 32'h0, 4'hF, 1'b0, 1'b0);
      tick();
      bus.s_ack_i = 1'b0;

      // bridge never acks
      drive(0, 32'h500, 32'h0, 4'hF, 1'b0, 1'b1);
      tick();
      chk("to_grant", bus.grant_o, 2'b01);
`ifdef XBUS_ARB_TIMEOUT_EN
      repeat (14) tick();
      chk("to_err_early", bus.m_err_o, 2'b00);
      tick();
      chk("to_err_pulse", bus.m_err_o, 2'b01);
      chk("to_busy_last", bus.busy_o, 1'b1);
      chk("to_no_ack", bus.m_ack_o, 2'b00);
      tick();
      chk("to_busy_fall", bus.busy_o, 1'b0);
      chk("to_err_clear", bus.m_err_o, 2'b00);
      tick();
      chk("to_regrant", bus.busy_o, 1'b1);
`else
      repeat (20) tick();
      chk("to_busy_hold", bus.busy_o, 1'b1);
      chk("to_err_zero", bus.m_err_o, 2'b00);
`endif

      // reset during BUSY aborts without ack and clears the pointer
      reset       = 1'b1;
      bus.s_ack_i = 1'b1;
      #1;
      chk("mrst_no_ack", bus.m_ack_o, 2'b00);
      tick();
      chk("mrst_grant", bus.grant_o, 2'b00);
      chk("mrst_busy", bus.busy_o, 1'b0);
      chk("mrst_stb", bus.s_stb_o, 1'b0);
      chk("mrst_cyc", bus.s_cyc_o, 1'b0);
      chk("mrst_adr", bus.s_adr_o, 32'h0);
      chk("mrst_ack", bus.m_ack_o, 2'b00);
      reset       = 1'b0;
      bus.s_ack_i = 1'b0;
      drive(1, 32'h600, 32'h0, 4'hF, 1'b0, 1'b1);
      tick();
      chk("mrst_ptr_zero", bus.grant_o, 2'b01);
      bus.s_ack_i = 1'b1;
      drive(0, 32'h500, 32'h0, 4'hF, 1'b0, 1'b0);
      drive(1, 32'h600, 32'h0, 4'hF, 1'b0, 1'b0);
      tick();
      bus.s_ack_i = 1'b0;
      tick();

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule

// File: doc/xbus_master_arbiter.md
XBUS_MASTER_ARBITER -- requirements
Module: xbus_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, XBUS address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, XBUS data width.
REQ-003 SHALL have parameter SELECT_WIDTH, default 4, byte-select width.
REQ-004 SHALL have parameter NUM_MASTERS, default 2, number of requesters (2..8).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles in BUSY before abort (used only with XBUS_ARB_TIMEOUT_EN).
REQ-006 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports m_adr_i/m_dat_i/m_sel_i  input  NUM_MASTERS*{ADDR,DATA,SELECT}_WIDTH  flattened per-master request fields; master k occupies slice k.
REQ-009 SHALL have ports m_we_i/m_stb_i/m_cyc_i  input  NUM_MASTERS  per-master write, strobe, cycle.
REQ-010 SHALL have ports m_dat_o  output  DATA_WIDTH  (shared read data), m_ack_o  output  NUM_MASTERS, m_err_o  output  NUM_MASTERS.
REQ-011 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o  output  (matching widths)  toward the XBUS-to-APB bridge; s_dat_i  input  DATA_WIDTH; s_ack_i  input  1.
REQ-012 SHALL have ports grant_o  output  NUM_MASTERS  one-hot current owner; busy_o  output  1  high in BUSY.

Function
REQ-013 Request of master k SHALL be m_stb_i[k] & m_cyc_i[k].
REQ-014 FSM SHALL have states IDLE and BUSY; IDLE->BUSY when any request is present, registering a one-hot grant.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer p; after granting k, p <= (k+1) mod NUM_MASTERS.
REQ-016 Latency: request sampled in IDLE at cycle t SHALL give grant_o/s_stb_o/s_cyc_o high at t+1.
REQ-017 In BUSY, s_* outputs SHALL combinationally mirror the granted master's fields; in IDLE, s_stb_o=s_cyc_o=0 and other s_* hold the last values.
REQ-018 m_ack_o[g] SHALL equal s_ack_i while BUSY; other m_ack_o bits SHALL be 0; m_dat_o SHALL equal s_dat_i.
REQ-019 BUSY->IDLE on s_ack_i; s_stb_o SHALL be 0 in the following cycle (one-cycle gap before next grant).
REQ-020 If the granted master drops m_cyc_i while BUSY, SHALL return to IDLE next cycle with no ack; p still advances.
REQ-021 Simultaneous s_ack_i and cyc drop SHALL be treated as normal completion (ack delivered).
REQ-022 Requests from non-granted masters SHALL be held pending, never dropped, and never generate ack.
REQ-023 Single requester SHALL be re-grantable back-to-back (every 2nd cycle minimum).

Reset
REQ-024 While reset is high: state IDLE, p=0, grant_o=0, busy_o=0, m_ack_o=0, m_err_o=0, s_stb_o=s_cyc_o=s_we_o=0, s_adr_o/s_dat_o/s_sel_o=0.
REQ-025 Reset asserted mid-BUSY SHALL abort the transfer without ack in the next cycle.

Configuration
REQ-026 Macro XBUS_ARB_TIMEOUT_EN defined: a counter SHALL clear on entering BUSY and increment each BUSY cycle; on reaching TIMEOUT_CYCLES-1 without s_ack_i, m_err_o[g] SHALL pulse one cycle, no ack, FSM -> IDLE, p advances.
REQ-027 Macro undefined: no counter logic; m_err_o SHALL be constant 0; BUSY waits indefinitely.

Structure
REQ-028 Shared package xbus_pkg SHALL hold state encodings (IDLE=1'b0, BUSY=1'b1) and default width constants.
REQ-029 Round-robin selection SHALL be one sub-module rr_arbiter (inputs req, pointer; output one-hot grant, index).

Verification
REQ-030 Reset then m0 read addr 0x10, bridge acks with 0xDEADBEEF -> grant_o=01 at t+1, m_ack_o=01, m_dat_o=0xDEADBEEF, m1 sees no ack.
REQ-031 m0 and m1 request in same cycle, both hold -> grants in order m0, m1, m0 (round-robin), one IDLE gap between each.
REQ-032 m1 write 0x20 data 0x12345678 sel 0xF while m0 idle -> s_adr_o=0x20, s_dat_o=0x12345678, s_we_o=1 mirrored while BUSY.
REQ-033 m0 granted, drops cyc before ack -> IDLE next cycle, no m_ack_o, next grant goes to m1 if requesting.
REQ-034 With XBUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, s_ack_i held 0 -> m_err_o[g] pulses once at BUSY cycle 16, busy_o falls next cycle; without macro, busy_o stays high.
REQ-035 Reset asserted during BUSY -> all outputs at reset values next cycle, p=0.
